shift_in_ctrl: RTL and testbench

Serial frame receiver controller. It sequences a serial-in shift register: detects frame start, generates a divided bit-sample strobe and counts bits. It transfers each completed word into a holding register with a valid/ready handshake toward the consumer. It sits between an external serial link (frame + data line) and the parallel word datapath, and reports overrun and short-frame errors.

---
 rtl/shift_in_ctrl_pkg.sv | 19 +
 rtl/shift_in_ctrl_if.sv | 30 +++
 rtl/shift_in_ctrl_sin_shreg.sv | 28 ++
 rtl/shift_in_ctrl.sv | 124 ++++++++++++
 tb/tb_shift_in_ctrl.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/shift_in_ctrl_pkg.sv
// Shared definitions for the serial frame receiver controller.
//   state_e : controller FSM states
//   ctr_w() : counter width helper, never below 1 bit
package shift_in_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2,
    TAIL  = 2'd3
  } state_e;

  // Bits needed to hold 0..n-1, with a floor of one bit so that
  // degenerate counts (n <= 1) still yield a legal vector.
  function automatic int unsigned ctr_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/shift_in_ctrl_if.sv
// Bus bundle between the serial link / word consumer and shift_in_ctrl.
//   frame, si        : serial link (frame active, data MSB first)
//   dout, dout_valid : holding register and its valid flag
//   dout_ready       : consumer accepts dout this cycle
//   busy             : controller not idle
//   overrun          : sticky, completed word dropped
//   short_err        : sticky, frame ended early
//   err_clr          : synchronous clear of the sticky flags
// master = link/consumer side, slave = controller side.
interface shift_in_ctrl_if #(parameter int unsigned WIDTH = 32);
  logic             frame;
  logic             si;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             busy;
  logic             overrun;
  logic             short_err;
  logic             err_clr;

  modport master (
    output frame, si, dout_ready, err_clr,
    input  dout, dout_valid, busy, overrun, short_err
  );

  modport slave (
    input  frame, si, dout_ready, err_clr,
    output dout, dout_valid, busy, overrun, short_err
  );
endinterface

// File: rtl/shift_in_ctrl_sin_shreg.sv
// WIDTH-bit serial-in / parallel-out shift register, MSB first.
//   clk, clr : clock, asynchronous active-high reset
//   i_clear  : synchronous clear (wins over i_en)
//   i_en     : shift i_si into the LSB end
//   i_si     : serial data
//   o_q      : parallel word; the first bit shifted in ends up in o_q[WIDTH-1]
module sin_shreg #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             i_clear,
  input  logic             i_en,
  input  logic             i_si,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr)          r_q <= '0;
    else if (i_clear) r_q <= '0;
    else if (i_en)    r_q <= {r_q[WIDTH-2:0], i_si};
  end

  assign o_q = r_q;

endmodule

// File: rtl/shift_in_ctrl.sv
// Serial frame receiver controller.
// Detects a rising frame edge, samples si every DIV clocks (first sample DIV
// clocks after the start edge), assembles WIDTH bits MSB first, then offers
// the word in a holding register with a valid/ready handshake. Reports
// dropped words (overrun) and frames that end early (short_err).
//   clk, clr : clock, asynchronous active-high reset
//   bus      : shift_in_ctrl_if slave modport (see interface header)
module shift_in_ctrl
  import shift_in_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIV   = 4
) (
  input  logic                 clk,
  input  logic                 clr,
  shift_in_ctrl_if.slave       bus
);

  localparam int unsigned CW = ctr_w(WIDTH + 1);
  localparam int unsigned DW = ctr_w(DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);

  state_e           r_state;
  logic             r_frame_q;
  logic [CW-1:0]    r_bits;
  logic [DW-1:0]    r_div;
  logic [WIDTH-1:0] r_dout;
  logic             r_valid;
  logic             r_busy;
  logic             r_overrun;
  logic             r_short;

  logic [WIDTH-1:0] w_word;
  logic             w_start;
  logic             w_tick;

  assign w_start = (r_state == IDLE) && bus.frame && !r_frame_q;
  // Sample only while the frame is still present; an aborting edge must not shift.
  assign w_tick  = (r_state == SHIFT) && bus.frame && (r_div == '0);

  sin_shreg #(.WIDTH(WIDTH)) u_shreg (
    .clk     (clk),
    .clr     (clr),
    .i_clear (w_start),
    .i_en    (w_tick),
    .i_si    (bus.si),
    .o_q     (w_word)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state   <= IDLE;
      r_frame_q <= 1'b1;   // a frame already high at release is not a start
      r_bits    <= '0;
      r_div     <= '0;
      r_dout    <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
      r_short   <= 1'b0;
    end else begin
      r_frame_q <= bus.frame;

      // Consumption and error clear come first so that a LOAD or a new
      // error later in this block overrides them at the same edge.
      if (r_valid && bus.dout_ready) r_valid <= 1'b0;
      if (bus.err_clr) begin
        r_overrun <= 1'b0;
        r_short   <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state <= SHIFT;
            r_busy  <= 1'b1;
            r_bits  <= '0;
            r_div   <= DIV_LAST;
          end
        end
        SHIFT: begin
          if (!bus.frame) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_short <= 1'b1;
          end else begin
            r_div <= (r_div == '0) ? DIV_LAST : r_div - 1'b1;
            if (w_tick) begin
              r_bits <= r_bits + 1'b1;
              if (r_bits == BIT_LAST) r_state <= LOAD;
            end
          end
        end
        LOAD: begin
          if (!r_valid || bus.dout_ready) begin
            r_dout  <= w_word;
            r_valid <= 1'b1;
          end else begin
            r_overrun <= 1'b1;
          end
          r_state <= TAIL;
        end
        TAIL: begin
          if (!bus.frame) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_valid;
  assign bus.busy       = r_busy;
  assign bus.overrun    = r_overrun;
  assign bus.short_err  = r_short;

endmodule

// File: tb/tb_shift_in_ctrl.sv
// Directed self-checking bench for shift_in_ctrl.
// u_dut2 (DIV=2) covers reset, normal receive, overrun, short frame and
// mid-frame clr; u_dut1 (DIV=1) covers the load-while-consumed case.
module tb_shift_in_ctrl;

  logic clk;
  logic clr;
  int unsigned n_checks;
  int unsigned n_errors;

  shift_in_ctrl_if #(.WIDTH(8)) b2 ();
  shift_in_ctrl_if #(.WIDTH(8)) b1 ();

  shift_in_ctrl #(.WIDTH(8), .DIV(2)) u_dut2 (.clk(clk), .clr(clr), .bus(b2));
  shift_in_ctrl #(.WIDTH(8), .DIV(1)) u_dut1 (.clk(clk), .clr(clr), .bus(b1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    assert (act === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, act, exp);
    end
  endtask

  task automatic set_frame(input bit sel, input logic v);
    if (sel) b1.frame = v; else b2.frame = v;
  endtask

  task automatic set_si(input bit sel, input logic v);
    if (sel) b1.si = v; else b2.si = v;
  endtask

  // Raise frame, hold each bit across its sample edge; returns 1ns after
  // the last sample edge with frame still high.
  task automatic send(input bit sel, input logic [7:0] w, input int unsigned div);
    @(negedge clk);
    set_frame(sel, 1'b1);
    set_si(sel, w[7]);
    @(posedge clk);
    for (int i = 7; i >= 0; i--) begin
      set_si(sel, w[i]);
      repeat (div) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    clr = 1'b1;
    b2.frame = 1'b1; b2.si = 1'b0; b2.dout_ready = 1'b0; b2.err_clr = 1'b0;
    b1.frame = 1'b0; b1.si = 1'b0; b1.dout_ready = 1'b0; b1.err_clr = 1'b0;

    // 1: frame high through reset release is ignored
    repeat (3) @(negedge clk);
    chk("rst_dout", b2.dout, 32'h0);
    chk("rst_valid", b2.dout_valid, 32'h0);
    chk("rst_busy", b2.busy, 32'h0);
    clr = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      chk("t1_valid", b2.dout_valid, 32'h0);
      chk("t1_busy", b2.busy, 32'h0);
    end
    chk("t1_dout", b2.dout, 32'h0);
    chk("t1_overrun", b2.overrun, 32'h0);
    chk("t1_short", b2.short_err, 32'h0);
    b2.frame = 1'b0;
    b2.dout_ready = 1'b1;
    @(negedge clk);

    // 2: normal receive 8'hB2 with ready high
    send(1'b0, 8'hB2, 2);
    @(negedge clk);
    chk("t2_busy_shift", b2.busy, 32'h1);
    chk("t2_valid_early", b2.dout_valid, 32'h0);
    @(negedge clk);
    chk("t2_valid", b2.dout_valid, 32'h1);
    chk("t2_dout", b2.dout, 32'hB2);
    @(negedge clk);
    chk("t2_valid_drop", b2.dout_valid, 32'h0);
    chk("t2_busy_tail", b2.busy, 32'h1);
    b2.frame = 1'b0;
    @(negedge clk);
    chk("t2_busy_idle", b2.busy, 32'h0);
    chk("t2_dout_hold", b2.dout, 32'hB2);

    // 3: overrun with consumer stalled
    b2.dout_ready = 1'b0;
    send(1'b0, 8'hB2, 2);
    repeat (2) @(negedge clk);
    chk("t3_valid1", b2.dout_valid, 32'h1);
    chk("t3_dout1", b2.dout, 32'hB2);
    b2.frame = 1'b0;
    send(1'b0, 8'h5A, 2);
    repeat (2) @(negedge clk);
    chk("t3_dout_kept", b2.dout, 32'hB2);
    chk("t3_valid_kept", b2.dout_valid, 32'h1);
    chk("t3_overrun", b2.overrun, 32'h1);
    b2.frame = 1'b0;
    b2.err_clr = 1'b1;
    @(negedge clk);
    b2.err_clr = 1'b0;
    chk("t3_overrun_clr", b2.overrun, 32'h0);
    b2.dout_ready = 1'b1;
    @(negedge clk);
    chk("t3_valid_drop", b2.dout_valid, 32'h0);

    // 4: short frame after 3 samples, then a good frame
    @(negedge clk);
    b2.frame = 1'b1; b2.si = 1'b1;
    @(posedge clk);
    repeat (6) @(posedge clk);
    #1;
    @(negedge clk);
    b2.frame = 1'b0;
    @(negedge clk);
    chk("t4_short", b2.short_err, 32'h1);
    chk("t4_busy", b2.busy, 32'h0);
    chk("t4_valid", b2.dout_valid, 32'h0);
    chk("t4_dout_kept", b2.dout, 32'hB2);
    send(1'b0, 8'h3C, 2);
    repeat (2) @(negedge clk);
    chk("t4_dout", b2.dout, 32'h3C);
    chk("t4_valid2", b2.dout_valid, 32'h1);
    chk("t4_short_sticky", b2.short_err, 32'h1);
    b2.frame = 1'b0;
    @(negedge clk);

    // 5: DIV=1, load on the same edge the previous word is consumed
    send(1'b1, 8'h11, 1);
    repeat (2) @(negedge clk);
    chk("t5_prev_dout", b1.dout, 32'h11);
    chk("t5_prev_valid", b1.dout_valid, 32'h1);
    b1.frame = 1'b0;
    send(1'b1, 8'hFF, 1);
    chk("t5_pre_dout", b1.dout, 32'h11);
    b1.dout_ready = 1'b1;
    @(posedge clk);
    #1;
    b1.dout_ready = 1'b0;
    @(negedge clk);
    chk("t5_dout", b1.dout, 32'hFF);
    chk("t5_valid", b1.dout_valid, 32'h1);
    chk("t5_overrun", b1.overrun, 32'h0);
    b1.frame = 1'b0;

    // 6: clr mid-frame, then frame must fall and rise again
    @(negedge clk);
    b2.frame = 1'b1; b2.si = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1;
    clr = 1'b1;
    #1;
    chk("t6_dout", b2.dout, 32'h0);
    chk("t6_valid", b2.dout_valid, 32'h0);
    chk("t6_busy", b2.busy, 32'h0);
    chk("t6_short", b2.short_err, 32'h0);
    chk("t6_dut1_dout", b1.dout, 32'h0);
    @(negedge clk);
    clr = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      chk("t6_hold_valid", b2.dout_valid, 32'h0);
      chk("t6_hold_busy", b2.busy, 32'h0);
    end
    b2.frame = 1'b0;
    send(1'b0, 8'hA5, 2);
    repeat (2) @(negedge clk);
    chk("t6_dout_a5", b2.dout, 32'hA5);
    chk("t6_valid_a5", b2.dout_valid, 32'h1);
    b2.frame = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
